// File: rtl/control_r.sv
// control_r: registered decoder for RV32I R-type (OP, opcode 0110011) instructions.
//
// Ports:
//   clk               system clock, rising-edge active
//   rst               synchronous active-high reset; clears every output register
//   instruction_word  32-bit instruction to decode
//   alu_ctrl          ALU operation select, {funct7[5], funct3} for supported encodings
//   reg_write         register-file write enable (asserted even when rd is x0)
//   rs1_addr          raw instruction_word[19:15]
//   rs2_addr          raw instruction_word[24:20]
//   rd_addr           raw instruction_word[11:7]
//   illegal           word is not a supported R-type encoding
//
// Outputs are registered, so results appear one cycle after the word is sampled.
module control_r (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_word,
  output logic [3:0]  alu_ctrl,
  output logic        reg_write,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        illegal
);

  localparam logic [6:0] OpcodeOp   = 7'b0110011;
  localparam logic [6:0] Funct7Base = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instruction_word[6:0];
  assign funct3 = instruction_word[14:12];
  assign funct7 = instruction_word[31:25];

  logic       valid;
  logic [3:0] alu_ctrl_d;
  logic       reg_write_d;
  logic       illegal_d;

  always_comb begin
    valid       = 1'b0;
    alu_ctrl_d  = 4'b0000;
    reg_write_d = 1'b0;
    illegal_d   = 1'b1;

    if (opcode == OpcodeOp) begin
      if (funct7 == Funct7Base) begin
        valid = 1'b1;
      end else if (funct7 == Funct7Alt) begin
        // Only SUB (000) and SRA (101) use the alternate funct7.
        valid = (funct3 == 3'b000) || (funct3 == 3'b101);
      end
    end

    if (valid) begin
      alu_ctrl_d  = {funct7[5], funct3};
      reg_write_d = 1'b1;
      illegal_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ctrl  <= 4'b0000;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
      rs1_addr  <= 5'd0;
      rs2_addr  <= 5'd0;
      rd_addr   <= 5'd0;
    end else begin
      alu_ctrl  <= alu_ctrl_d;
      reg_write <= reg_write_d;
      illegal   <= illegal_d;
      rs1_addr  <= instruction_word[19:15];
      rs2_addr  <= instruction_word[24:20];
      rd_addr   <= instruction_word[11:7];
    end
  end

endmodule

// File: tb/tb_control_r.sv
// Self-checking bench for control_r: directed vectors plus randomized words checked
// against a table-driven reference model of the R-type decode rules.
module tb_control_r;

  logic        clk;
  logic        rst;
  logic [31:0] instruction_word;
  logic [3:0]  alu_ctrl;
  logic        reg_write;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        illegal;

  int unsigned n_tests;
  int unsigned n_fail;

  control_r dut (
    .clk              (clk),
    .rst              (rst),
    .instruction_word (instruction_word),
    .alu_ctrl         (alu_ctrl),
    .reg_write        (reg_write),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rd_addr          (rd_addr),
    .illegal          (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: look the (funct7, funct3) pair up in a list of the ten supported
  // operations and their ALU codes.
  typedef struct packed {
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] code;
  } op_t;

  op_t ops [10];

  initial begin
    ops[0] = '{7'h00, 3'd0, 4'd0};   // ADD
    ops[1] = '{7'h20, 3'd0, 4'd8};   // SUB
    ops[2] = '{7'h00, 3'd1, 4'd1};   // SLL
    ops[3] = '{7'h00, 3'd2, 4'd2};   // SLT
    ops[4] = '{7'h00, 3'd3, 4'd3};   // SLTU
    ops[5] = '{7'h00, 3'd4, 4'd4};   // XOR
    ops[6] = '{7'h00, 3'd5, 4'd5};   // SRL
    ops[7] = '{7'h20, 3'd5, 4'd13};  // SRA
    ops[8] = '{7'h00, 3'd6, 4'd6};   // OR
    ops[9] = '{7'h00, 3'd7, 4'd7};   // AND
  end

  // Packed expectation: {illegal, reg_write, alu_ctrl, rs1, rs2, rd}
  function automatic logic [20:0] model(input logic [31:0] w);
    logic [3:0] code;
    logic       ok;
    ok   = 1'b0;
    code = 4'd0;
    if (w[6:0] == 7'd51) begin
      foreach (ops[i]) begin
        if (ops[i].f7 == w[31:25] && ops[i].f3 == w[14:12]) begin
          ok   = 1'b1;
          code = ops[i].code;
        end
      end
    end
    return {~ok, ok, code, w[19:15], w[24:20], w[11:7]};
  endfunction

  task automatic check_outputs(input string tag, input logic [20:0] e);
    check({tag, ".illegal"},   32'(illegal),   32'(e[20]));
    check({tag, ".reg_write"}, 32'(reg_write), 32'(e[19]));
    check({tag, ".alu_ctrl"},  32'(alu_ctrl),  32'(e[18:15]));
    check({tag, ".rs1"},       32'(rs1_addr),  32'(e[14:10]));
    check({tag, ".rs2"},       32'(rs2_addr),  32'(e[9:5]));
    check({tag, ".rd"},        32'(rd_addr),   32'(e[4:0]));
  endtask

  // Apply a word, clock once, and check outputs just after the edge.
  task automatic apply(input string tag, input logic [31:0] w);
    instruction_word = w;
    @(posedge clk);
    #1;
    check_outputs(tag, model(w));
  endtask

  logic [31:0] w;
  logic [31:0] prev;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    instruction_word = 32'hFFFF_FFFF;
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outputs("reset", 21'd0);

    // First edge after release decodes normally.
    @(negedge clk);
    rst = 1'b0;
    apply("add", 32'b0000000_00100_10101_000_00101_0110011);
    check("add.abs", {alu_ctrl, reg_write, illegal, rs1_addr, rs2_addr, rd_addr},
          {4'b0000, 1'b1, 1'b0, 5'd21, 5'd4, 5'd5, 11'd0} >> 11);
    apply("sub", 32'b0100000_00101_10101_000_00110_0110011);
    check("sub.alu_abs", 32'(alu_ctrl), 32'd8);
    apply("sll", 32'b0000000_00100_10101_001_00101_0110011);
    check("sll.alu_abs", 32'(alu_ctrl), 32'd1);

    // Back-to-back sweep of all ten ops with varying register fields.
    for (int i = 0; i < 10; i++) begin
      w = {ops[i].f7, 5'(i + 3), 5'(31 - i), ops[i].f3, 5'(i), 7'b0110011};
      apply($sformatf("sweep%0d", i), w);
    end
    apply("sra", 32'b0100000_00011_00010_101_00001_0110011);
    check("sra.alu_abs", 32'(alu_ctrl), 32'd13);

    // Illegal encodings; fields still pass through.
    apply("ill_opimm", 32'b0000000_00100_10101_000_00101_0010011);
    check("ill_opimm.abs", 32'({illegal, reg_write, alu_ctrl}), 32'b100000);
    apply("ill_f7",    32'b0000001_00100_10101_000_00101_0110011);
    apply("ill_alt111", 32'b0100000_00100_10101_111_00101_0110011);
    check("ill_alt111.rs1", 32'(rs1_addr), 32'd21);

    // Mid-stream reset discards the in-flight decode.
    instruction_word = 32'b0000000_00100_10101_000_00101_0110011;
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs("midreset", 21'd0);
    rst = 1'b0;
    apply("post_reset", 32'b0100000_00101_10101_101_00110_0110011);

    // Mid-cycle change of input does not disturb outputs before the next edge.
    prev = instruction_word;
    @(negedge clk);
    instruction_word = 32'h0000_0013;
    #2;
    check_outputs("hold", model(prev));

    // Random: bias half the words toward the OP opcode and legal funct7 values.
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        w[6:0] = 7'b0110011;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: ;
        endcase
      end
      apply($sformatf("rand%0d", i), w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
